// File: rtl/hex_disp_ctrl_if.sv
// Register bus between a host and hex_disp_ctrl: write/read strobes, address, write and read data.
interface hex_disp_ctrl_if #(
  parameter int DBITS = 32
) ();
  logic             wr_en;
  logic             rd_en;
  logic [1:0]       addr;
  logic [DBITS-1:0] wdata;
  logic [DBITS-1:0] rdata;

  modport master (output wr_en, output rd_en, output addr, output wdata, input rdata);
  modport slave  (input wr_en, input rd_en, input addr, input wdata, output rdata);
endinterface

// File: rtl/hex_disp_ctrl.sv
// Memory-mapped seven-segment hex display controller with leading-zero suppression.
// Optional per-digit blinking is compiled in when HEX_DISP_BLINK_EN is defined.
module hex_disp_ctrl #(
  parameter int NDIGITS   = 4,
  parameter int DBITS     = 32,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                 clk,
  input  logic                 reset,
  hex_disp_ctrl_if.slave       bus,
  output logic [7*NDIGITS-1:0] hex_out
);

  localparam int DW = 4 * NDIGITS;

  logic [DW-1:0]        r_data;
  logic                 r_lzs;
  logic [DBITS-1:0]     r_rdata;
  logic [7*NDIGITS-1:0] r_hex;

  logic                 w_data_we;
  logic                 w_ctrl_we;
  logic [DBITS+15:0]    w_wdata_ext;
  logic [DBITS+15:0]    w_ctrl_view;
  logic [DBITS-1:0]     w_rd_mux;
  logic [7*NDIGITS-1:0] w_hex;
  logic                 w_zero_run;
  logic                 w_blank;
  logic                 w_unused_bits;

`ifdef HEX_DISP_BLINK_EN
  localparam int                CNT_W   = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic [NDIGITS-1:0] r_blink_mask;
  logic [CNT_W-1:0]   r_blink_cnt;
  logic               r_phase;
`endif

  // Active-low gfedcba glyphs for hex digits 0-F.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // Zero padding keeps the CTRL field slices in range for narrow buses.
  assign w_wdata_ext   = {16'h0000, bus.wdata};
  assign w_data_we     = bus.wr_en && (bus.addr == 2'd0);
  assign w_ctrl_we     = bus.wr_en && (bus.addr == 2'd1);
  assign w_unused_bits = ^{w_wdata_ext, w_ctrl_view};

  // DATA and LZS registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= {DW{1'b0}};
      r_lzs  <= 1'b0;
    end else begin
      if (w_data_we) r_data <= bus.wdata[DW-1:0];
      if (w_ctrl_we) r_lzs  <= bus.wdata[0];
    end
  end

`ifdef HEX_DISP_BLINK_EN
  // Blink mask, phase counter and phase; a CTRL write restarts the phase from 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_mask <= {NDIGITS{1'b0}};
      r_blink_cnt  <= {CNT_W{1'b0}};
      r_phase      <= 1'b0;
    end else if (w_ctrl_we) begin
      r_blink_mask <= w_wdata_ext[8 +: NDIGITS];
      r_blink_cnt  <= {CNT_W{1'b0}};
      r_phase      <= 1'b0;
    end else if (r_blink_cnt == CNT_MAX) begin
      r_blink_cnt  <= {CNT_W{1'b0}};
      r_phase      <= ~r_phase;
    end else begin
      r_blink_cnt  <= r_blink_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

  // Readback view of CTRL and the address-selected read mux.
  always_comb begin
    w_ctrl_view    = {(DBITS+16){1'b0}};
    w_ctrl_view[0] = r_lzs;
`ifdef HEX_DISP_BLINK_EN
    w_ctrl_view[8 +: NDIGITS] = r_blink_mask;
`endif
    case (bus.addr)
      2'd0:    w_rd_mux = {{(DBITS-DW){1'b0}}, r_data};
      2'd1:    w_rd_mux = w_ctrl_view[DBITS-1:0];
      default: w_rd_mux = {DBITS{1'b0}};
    endcase
  end

  // Read data register; registers are sampled before any same-edge write lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= {DBITS{1'b0}};
    end else if (bus.rd_en) begin
      r_rdata <= w_rd_mux;
    end else begin
      r_rdata <= r_rdata;
    end
  end

  // Glyph selection per digit; the zero run is tracked from the most significant digit down.
  always_comb begin
    w_hex      = {(7*NDIGITS){1'b0}};
    w_zero_run = 1'b1;
    w_blank    = 1'b0;
    for (int k = NDIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run & (r_data[4*k +: 4] == 4'h0);
      w_blank    = r_lzs & w_zero_run & (k != 0);
`ifdef HEX_DISP_BLINK_EN
      w_blank    = w_blank | (r_phase & r_blink_mask[k]);
`endif
      if (w_blank) begin
        w_hex[7*k +: 7] = 7'h7F;
      end else begin
        w_hex[7*k +: 7] = seg7(r_data[4*k +: 4]);
      end
    end
  end

  // Segment output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hex <= {NDIGITS{7'h40}};
    end else begin
      r_hex <= w_hex;
    end
  end

  assign bus.rdata = r_rdata;
  assign hex_out   = r_hex;

endmodule
